// File: rtl/conv1d_3rd_mac_engine.sv
// conv1d_3rd_mac_engine: one filter row of a 3-tap conv1d, MACs In_Depth channels per position; CONV1D_3RD_RELU_EN adds ReLU.
// Latency 1 + Out_Width*(In_Depth+2) cycles Start->Done; no backpressure, consumer takes every Result_Valid.
module conv1d_3rd_mac_engine #(
  parameter int Bit_width = 16,
  parameter int Frac_bits = 8,
  parameter int In_Depth  = 16,
  parameter int Out_Width = 126,
  parameter int Acc_width = 2*Bit_width+4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Start,
  input  logic [Bit_width-1:0] Bias,
  output logic                 Busy,
  output logic                 Read_Enable,
  output logic [3:0]           Read_Depth,
  output logic [7:0]           Read_Width,
  input  logic [Bit_width-1:0] data_in_0,
  input  logic [Bit_width-1:0] data_in_1,
  input  logic [Bit_width-1:0] data_in_2,
  output logic                 Weight_Read_Enable,
  output logic [3:0]           Weight_Addr,
  input  logic [Bit_width-1:0] weight_0,
  input  logic [Bit_width-1:0] weight_1,
  input  logic [Bit_width-1:0] weight_2,
  output logic                 Result_Valid,
  output logic [7:0]           Result_Width,
  output logic [Bit_width-1:0] Result_Data,
  output logic                 Done
);

  localparam int Prod_width = 2*Bit_width;
  localparam logic [3:0] last_depth = 4'(In_Depth-1);
  localparam logic [7:0] last_pos   = 8'(Out_Width-1);
  localparam logic signed [Acc_width-1:0] acc_max = {1'b0, {(Acc_width-1){1'b1}}};
  localparam logic signed [Acc_width-1:0] acc_min = ~acc_max;
  localparam logic signed [Acc_width-1:0] res_max = {{(Acc_width-Bit_width+1){1'b0}}, {(Bit_width-1){1'b1}}};
  localparam logic signed [Acc_width-1:0] res_min = ~res_max;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FINISH} state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   depth_cnt;
  logic [7:0]                   pos_cnt;
  logic [Bit_width-1:0]         bias_q;
  logic                         acc_en;
  logic signed [Acc_width-1:0]  acc, acc_sum, acc_shift, mac;
  logic signed [Acc_width:0]    acc_wide;
  logic signed [Prod_width-1:0] prod_0, prod_1, prod_2;
  logic [Bit_width-1:0]         res_nxt, res_dat;
  logic [7:0]                   res_pos;

  function automatic logic signed [Acc_width-1:0] sext_prod(input logic signed [Prod_width-1:0] p);
    return {{(Acc_width-Prod_width){p[Prod_width-1]}}, p};
  endfunction

  function automatic logic signed [Acc_width-1:0] bias_acc(input logic [Bit_width-1:0] b);
    logic signed [Acc_width-1:0] t;
    t = {{(Acc_width-Bit_width){b[Bit_width-1]}}, b};
    return t <<< Frac_bits;
  endfunction

  assign prod_0   = $signed(data_in_0) * $signed(weight_0);
  assign prod_1   = $signed(data_in_1) * $signed(weight_1);
  assign prod_2   = $signed(data_in_2) * $signed(weight_2);
  assign mac      = sext_prod(prod_0) + sext_prod(prod_1) + sext_prod(prod_2);
  assign acc_wide = {acc[Acc_width-1], acc} + {mac[Acc_width-1], mac};

  // Accumulator clamps instead of wrapping so extreme rows still saturate the right way.
  always_comb begin
    acc_sum = acc_wide[Acc_width-1:0];
    if (acc_wide[Acc_width] != acc_wide[Acc_width-1])
      acc_sum = acc_wide[Acc_width] ? acc_min : acc_max;
  end

  assign acc_shift = acc_sum >>> Frac_bits;

  always_comb begin
    res_nxt = acc_shift[Bit_width-1:0];
    if (acc_shift > res_max)
      res_nxt = res_max[Bit_width-1:0];
    else if (acc_shift < res_min)
      res_nxt = res_min[Bit_width-1:0];
`ifdef CONV1D_3RD_RELU_EN
    if (res_nxt[Bit_width-1])
      res_nxt = '0;
`endif
  end

  always_comb begin
    state_nxt          = state;
    Busy               = 1'b0;
    Read_Enable        = 1'b0;
    Read_Depth         = '0;
    Read_Width         = '0;
    Result_Valid       = 1'b0;
    Done               = 1'b0;
    case (state)
      IDLE:   if (Start) state_nxt = READ;
      READ: begin
        Busy        = 1'b1;
        Read_Enable = 1'b1;
        Read_Depth  = depth_cnt;
        Read_Width  = pos_cnt;
        if (depth_cnt == last_depth) state_nxt = DRAIN;
      end
      DRAIN: begin
        Busy      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        Busy         = 1'b1;
        Result_Valid = 1'b1;
        state_nxt    = (pos_cnt == last_pos) ? FINISH : READ;
      end
      FINISH: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    Weight_Read_Enable = Read_Enable;
    Weight_Addr        = Read_Depth;
  end

  assign Result_Width = res_pos;
  assign Result_Data  = res_dat;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      depth_cnt <= '0;
      pos_cnt   <= '0;
      bias_q    <= '0;
      acc_en    <= 1'b0;
      acc       <= '0;
      res_dat   <= '0;
      res_pos   <= '0;
    end else begin
      state  <= state_nxt;
      acc_en <= (state == READ);
      if (acc_en) acc <= acc_sum;
      case (state)
        IDLE: if (Start) begin
          bias_q    <= Bias;
          pos_cnt   <= '0;
          depth_cnt <= '0;
          acc       <= bias_acc(Bias);
        end
        READ: depth_cnt <= (depth_cnt == last_depth) ? 4'd0 : depth_cnt + 4'd1;
        // Taps from the last read land this cycle, so capture the result from acc_sum.
        DRAIN: begin
          res_dat <= res_nxt;
          res_pos <= pos_cnt;
        end
        EMIT: if (pos_cnt != last_pos) begin
          pos_cnt <= pos_cnt + 8'd1;
          acc     <= bias_acc(bias_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_3rd_mac_engine.sv
// Bench for conv1d_3rd_mac_engine: RAM/ROM models, reference row computed with plain integer arithmetic,
// results and Done times pushed to queues at Start and popped by an independent monitor.
module tb_conv1d_3rd_mac_engine;
  localparam int BW = 16;
  localparam int ID = 16;
  localparam int OW = 4;
  localparam int ROW_CYC = 1 + OW*(ID+2);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          Start = 1'b0;
  logic [BW-1:0] Bias = '0;
  logic          Busy, Read_Enable, Weight_Read_Enable, Result_Valid, Done;
  logic [3:0]    Read_Depth, Weight_Addr;
  logic [7:0]    Read_Width, Result_Width;
  logic [BW-1:0] Result_Data;
  logic [BW-1:0] data_in_0 = '0, data_in_1 = '0, data_in_2 = '0;
  logic [BW-1:0] weight_0 = '0, weight_1 = '0, weight_2 = '0;

  conv1d_3rd_mac_engine #(.Bit_width(BW), .Frac_bits(8), .In_Depth(ID), .Out_Width(OW)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Bias(Bias), .Busy(Busy),
    .Read_Enable(Read_Enable), .Read_Depth(Read_Depth), .Read_Width(Read_Width),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .Weight_Read_Enable(Weight_Read_Enable), .Weight_Addr(Weight_Addr),
    .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2),
    .Result_Valid(Result_Valid), .Result_Width(Result_Width), .Result_Data(Result_Data),
    .Done(Done)
  );

  typedef struct packed { int pos; logic [15:0] dat; } res_t;

  logic signed [15:0] dmem [ID][OW+2];
  logic signed [15:0] wmem [ID][3];
  res_t exp_q[$];
  int   done_q[$];
  int   n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, rd_idx = 0;
  logic [15:0] last_dat = '0;
  int          last_pos = 0;

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Reference: exact integer convolution for one position, then floor-shift, clamp and optional ReLU.
  function automatic logic [15:0] model(input int p, input logic [15:0] b);
    longint s;
    s = longint'($signed(b)) * 256;
    for (int d = 0; d < ID; d++)
      for (int k = 0; k < 3; k++)
        s += longint'(dmem[d][p+k]) * longint'(wmem[d][k]);
    s = s >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV1D_3RD_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  function automatic logic [15:0] rnd(input int amp);
    int v;
    v = int'($urandom_range(2*amp, 0)) - amp;
    return 16'(v);
  endfunction

  task automatic fill_const(input logic [15:0] dv, input logic [15:0] wv);
    for (int d = 0; d < ID; d++) begin
      for (int x = 0; x < OW+2; x++) dmem[d][x] = dv;
      for (int k = 0; k < 3; k++) wmem[d][k] = wv;
    end
  endtask

  task automatic fill_rand(input int amp);
    for (int d = 0; d < ID; d++) begin
      for (int x = 0; x < OW+2; x++) dmem[d][x] = rnd(amp);
      for (int k = 0; k < 3; k++) wmem[d][k] = rnd(amp);
    end
  endtask

  // Data RAM / weight ROM: address seen in one cycle, taps driven for the next; junk otherwise.
  logic       ram_re, rom_re;
  logic [3:0] ram_d, rom_a;
  logic [7:0] ram_w;
  initial forever begin
    @(negedge CLK);
    ram_re = Read_Enable; ram_d = Read_Depth; ram_w = Read_Width;
    rom_re = Weight_Read_Enable; rom_a = Weight_Addr;
    @(posedge CLK); #1;
    if (ram_re) begin
      data_in_0 = dmem[ram_d][int'(ram_w)];
      data_in_1 = dmem[ram_d][int'(ram_w)+1];
      data_in_2 = dmem[ram_d][int'(ram_w)+2];
    end else begin
      data_in_0 = 16'($urandom); data_in_1 = 16'($urandom); data_in_2 = 16'($urandom);
    end
    if (rom_re) begin
      weight_0 = wmem[rom_a][0]; weight_1 = wmem[rom_a][1]; weight_2 = wmem[rom_a][2];
    end else begin
      weight_0 = 16'($urandom); weight_1 = 16'($urandom); weight_2 = 16'($urandom);
    end
  end

  // Monitor: read sequencing, result scoreboard, output hold and Done timing.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("weight_re_eq_re", 64'(Weight_Read_Enable), 64'(Read_Enable));
      chk("weight_addr_eq_depth", 64'(Weight_Addr), 64'(Read_Depth));
      if (Read_Enable) begin
        chk("read_depth", 64'(Read_Depth), 64'(rd_idx % ID));
        chk("read_width", 64'(Read_Width), 64'(rd_idx / ID));
        rd_idx++;
      end
      if (Result_Valid) begin
        if (exp_q.size() == 0) flag("result_unexpected");
        else begin
          res_t e;
          e = exp_q.pop_front();
          chk("result_width", 64'(Result_Width), 64'(e.pos));
          chk("result_data", 64'(Result_Data), 64'(e.dat));
          last_dat = e.dat;
          last_pos = e.pos;
        end
      end else begin
        chk("result_hold", {40'd0, Result_Width, Result_Data}, {40'd0, 8'(last_pos), last_dat});
      end
      if (Done) begin
        if (done_q.size() == 0) flag("done_unexpected");
        else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        done_cnt++;
      end
    end
  end

  task automatic start_row(input logic [15:0] b);
    for (int p = 0; p < OW; p++) exp_q.push_back('{pos: p, dat: model(p, b)});
    @(posedge CLK); #1;
    Start = 1'b1; Bias = b; rd_idx = 0;
    done_q.push_back(cyc + ROW_CYC);
    @(posedge CLK); #1;
    Start = 1'b0; Bias = 16'($urandom);
  endtask

  task automatic wait_done();
    int c0, k;
    c0 = done_cnt; k = 0;
    while (done_cnt == c0 && k < ROW_CYC + 20) begin
      @(posedge CLK);
      k++;
    end
    if (done_cnt == c0) flag("done_timeout");
    #1;
    chk("busy_after_done", 64'(Busy), 64'd0);
  endtask

  task automatic run_row(input logic [15:0] b);
    start_row(b);
    wait_done();
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {19'd0, Busy, Read_Enable, Read_Depth, Read_Width, Weight_Read_Enable, Weight_Addr,
               Result_Valid, Result_Width, Result_Data, Done}, 64'd0);
  endtask

  initial begin
    int c0;
    #1 RST_N = 1'b0;
    #1 check_outputs_zero("reset_state");
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    fill_const(16'h0100, 16'h0080);          // 48 * 0.5 = 24.0
    run_row(16'h0000);
    fill_const(16'h0100, 16'h0000);          // bias only, -1.0
    run_row(16'hFF00);
    fill_const(16'h7FFF, 16'h7FFF);          // positive saturation
    run_row(16'h7FFF);
    fill_const(16'h7FFF, 16'h8001);          // negative saturation
    run_row(16'h7FFF);

    // Start pulse mid-row must be ignored.
    fill_rand(16'h00FF);
    start_row(16'($urandom));
    repeat (8) @(posedge CLK);
    #1 Start = 1'b1; Bias = 16'($urandom);
    @(posedge CLK); #1 Start = 1'b0;
    wait_done();

    for (int r = 0; r < 6; r++) begin
      fill_rand((r % 2 == 0) ? 16'h00FF : 16'h3FFF);
      run_row(rnd(16'h7FFF));
    end

    // Start during FINISH is dropped.
    fill_rand(16'h00FF);
    c0 = done_cnt;
    start_row(rnd(16'h0FFF));
    repeat (ROW_CYC - 1) @(posedge CLK);
    #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
    chk("finish_start_busy_0", 64'(Busy), 64'd0);
    @(posedge CLK); #1;
    chk("finish_start_busy_1", 64'(Busy), 64'd0);
    chk("finish_done_seen", 64'(done_cnt), 64'(c0 + 1));

    // Reset during READ of position 2 aborts the row without Done.
    fill_rand(16'h3FFF);
    start_row(rnd(16'h7FFF));
    repeat (39) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_outputs_zero("abort_outputs");
    exp_q.delete();
    done_q.delete();
    last_dat = '0;
    last_pos = 0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    fill_rand(16'h00FF);
    run_row(rnd(16'h7FFF));

    repeat (4) @(posedge CLK);
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    chk("dones_drained", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
